// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the 4-requester round-robin burst arbiter/mux.
//   NUM_REQ : number of requester channels (fixed at 4)
//   SEL_W   : width of a requester index
//   state_t : arbiter FSM state
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational rotating-priority search over four requests. Starting at
// index ptr and walking ptr+1, ptr+2, ... (mod 4), returns the first set bit.
//   req   : request vector, bit i = requester i
//   ptr   : requester with highest priority this round
//   found : at least one request is set
//   idx   : index of the selected requester (meaningful only when found)
// -----------------------------------------------------------------------------
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  always_comb begin
    logic [SEL_W-1:0] cand;
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned, which would otherwise infer a latch.
    found = |req;
    idx   = ptr;
    cand  = ptr;
    // Walk from the farthest offset back to offset 0 so the closest set bit
    // to ptr is the last one written and therefore wins. The index addition
    // wraps naturally at SEL_W bits, giving the mod-4 rotation.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Four-requester round-robin arbiter feeding a registered 4:1 output mux.
// A grant lasts up to MAX_BURST beats, or ends early when the granted
// requester goes idle while it is allowed to send. Each grant costs one IDLE
// cycle for arbitration.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : per-requester beat valid
//   in_data   : requester i data at [i*WIDTH +: WIDTH]
//   in_ready  : per-requester beat accept (combinational)
//   out_valid : registered output beat valid
//   out_data  : registered output beat data
//   out_ready : downstream accept
//   sel       : registered select of the current / most recent grant
//   gnt       : registered one-hot grant, zero when nothing is granted
//   busy      : high while a grant is active
// -----------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4   // 1..16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         in_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   in_data,
  output logic [NUM_REQ-1:0]         in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [SEL_W-1:0]           sel,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy
);

  localparam int              CNT_W     = 5;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic              found;
  logic [SEL_W-1:0]  pick;
  logic [WIDTH-1:0]  sel_data;
  logic              out_free;
  logic              xfer;
  logic              req_idle;
  logic              grant_exit;

  rr_pick4 u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  // Output register can take a beat when empty or being drained this cycle.
  assign out_free = !out_valid || out_ready;

  always_comb begin
    in_ready = '0;
    if (state == ST_GRANT) in_ready[sel] = out_free;
  end

  always_comb begin
    case (sel)
      2'd0:    sel_data = in_data[0*WIDTH +: WIDTH];
      2'd1:    sel_data = in_data[1*WIDTH +: WIDTH];
      2'd2:    sel_data = in_data[2*WIDTH +: WIDTH];
      default: sel_data = in_data[3*WIDTH +: WIDTH];
    endcase
  end

  assign xfer       = (state == ST_GRANT) && in_valid[sel] && out_free;
  // Idle only counts when the requester was offered a slot; a stalled
  // output keeps the grant alive.
  assign req_idle   = (state == ST_GRANT) && !in_valid[sel] && out_free;
  assign grant_exit = req_idle || (xfer && (beat_cnt == LAST_BEAT));
  assign busy       = (state == ST_GRANT);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= '0;
      gnt       <= '0;
      ptr       <= '0;
      beat_cnt  <= '0;
    end else begin
      // Output register: load on a beat, otherwise drain when accepted.
      // This runs in both states so a pending beat never blocks arbitration.
      if (xfer) begin
        out_data  <= sel_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (found) begin
            sel      <= pick;
            gnt      <= NUM_REQ'(1) << pick;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (xfer) beat_cnt <= beat_cnt + 1'b1;
          if (grant_exit) begin
            // sel holds so it still names the most recent grant.
            ptr   <= sel + 1'b1;
            gnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Directed self-checking bench for mux_rr_arbiter (WIDTH=8, MAX_BURST=4).
// Inputs are driven 1 ns after each rising edge and outputs are sampled there.
// Lane i data is {i, cycle} so every output beat identifies its source lane
// and the cycle it was taken in.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int WIDTH = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ*WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]       in_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ready;
  logic [SEL_W-1:0]         sel;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [31:0] d1;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_d(input int k, input int c);
    return {24'h0, 4'(k), 4'(c)};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NUM_REQ; i++) in_data[i*WIDTH +: WIDTH] = {4'(i), 4'(cyc)};
  endtask

  // Advance one clock; afterwards the data taken at that edge was cycle cyc-1.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_data();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    drive_data();
    #1;
    // Reset values, asserted before any clock edge.
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_sel",       32'(sel),       0);
    check("rst_gnt",       32'(gnt),       0);
    check("rst_busy",      32'(busy),      0);
    check("rst_in_ready",  32'(in_ready),  0);
    step();
    step();
    rst_n = 1'b1;

    // Single beat from requester 0 with data 0x11.
    in_valid = 4'b0001;
    in_data[7:0] = 8'h11;
    #1;
    check("t31_idle_ready", 32'(in_ready), 0);
    check("t31_idle_gnt",   32'(gnt),      0);
    step();
    in_data[7:0] = 8'h11;
    #1;
    check("t31_gnt",       32'(gnt),       1);
    check("t31_busy",      32'(busy),      1);
    check("t31_sel",       32'(sel),       0);
    check("t31_in_ready",  32'(in_ready),  1);
    check("t31_ov_before", 32'(out_valid), 0);
    step();
    check("t31_out_valid", 32'(out_valid), 1);
    check("t31_out_data",  32'(out_data),  'h11);
    check("t31_busy2",     32'(busy),      1);
    in_valid = '0;
    step();
    check("t31_exit_busy", 32'(busy),      0);
    check("t31_exit_gnt",  32'(gnt),       0);
    check("t31_exit_sel",  32'(sel),       0);
    check("t31_drain",     32'(out_valid), 0);

    // All four valid: grants 0,1,2,3,0 with 4 beats each, one IDLE gap.
    do_reset();
    in_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int k;
      k = g % 4;
      step();
      check($sformatf("t32_g%0d_gnt", g), 32'(gnt), 32'(1 << k));
      check($sformatf("t32_g%0d_ov0", g), 32'(out_valid), 0);
      for (int b = 1; b <= 4; b++) begin
        step();
        check($sformatf("t32_g%0d_b%0d_ov", g, b), 32'(out_valid), 1);
        check($sformatf("t32_g%0d_b%0d_d", g, b), 32'(out_data), exp_d(k, cyc - 1));
        check($sformatf("t32_g%0d_b%0d_gnt", g, b), 32'(gnt), (b < 4) ? 32'(1 << k) : 0);
      end
      check($sformatf("t32_g%0d_busy", g), 32'(busy), 0);
    end

    // Requester 2 sends 2 beats then idles; ptr moves to 3.
    in_valid = 4'b0100;
    step();
    check("t33_gnt", 32'(gnt), 'b0100);
    step();
    step();
    check("t33_b2_data", 32'(out_data), exp_d(2, cyc - 1));
    check("t33_b2_gnt",  32'(gnt),      'b0100);
    in_valid = '0;
    step();
    check("t33_exit_gnt",  32'(gnt),  0);
    check("t33_exit_busy", 32'(busy), 0);
    check("t33_exit_sel",  32'(sel),  2);
    in_valid = 4'b1010;
    step();
    check("t33_next_gnt", 32'(gnt), 'b1000);
    check("t33_next_sel", 32'(sel), 3);
    in_valid = '0;
    step();
    check("t33_end_busy", 32'(busy), 0);

    // Requester 1 burst with a 5-cycle output stall after the first beat.
    in_valid = 4'b0010;
    step();
    check("t34_gnt", 32'(gnt), 'b0010);
    step();
    d1 = exp_d(1, cyc - 1);
    check("t34_b1_data", 32'(out_data), d1);
    out_ready = 1'b0;
    #1;
    check("t34_stall_ready", 32'(in_ready), 0);
    for (int s = 0; s < 5; s++) begin
      step();
      check($sformatf("t34_s%0d_data", s),  32'(out_data),  d1);
      check($sformatf("t34_s%0d_ov", s),    32'(out_valid), 1);
      check($sformatf("t34_s%0d_gnt", s),   32'(gnt),       'b0010);
      check($sformatf("t34_s%0d_ready", s), 32'(in_ready),  0);
    end
    out_ready = 1'b1;
    #1;
    check("t34_release_ready", 32'(in_ready), 'b0010);
    for (int b = 2; b <= 4; b++) begin
      step();
      check($sformatf("t34_b%0d_data", b), 32'(out_data), exp_d(1, cyc - 1));
      check($sformatf("t34_b%0d_gnt", b),  32'(gnt), (b < 4) ? 32'('b0010) : 0);
    end
    in_valid = '0;
    step();
    check("t34_drain", 32'(out_valid), 0);

    // Reset during beat 2 of a requester-3 burst.
    in_valid = 4'b1000;
    step();
    check("t35_gnt", 32'(gnt), 'b1000);
    step();
    check("t35_b1_data", 32'(out_data), exp_d(3, cyc - 1));
    rst_n = 1'b0;
    #1;
    check("t35_rst_ov",    32'(out_valid), 0);
    check("t35_rst_data",  32'(out_data),  0);
    check("t35_rst_gnt",   32'(gnt),       0);
    check("t35_rst_busy",  32'(busy),      0);
    check("t35_rst_ready", 32'(in_ready),  0);
    check("t35_rst_sel",   32'(sel),       0);
    step();
    check("t35_hold_ov", 32'(out_valid), 0);
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    step();
    check("t35_after_gnt", 32'(gnt),       'b0001);
    check("t35_after_ov",  32'(out_valid), 0);

    // 1010 from IDLE with ptr=0: requester 1 first, then 3.
    do_reset();
    in_valid = 4'b1010;
    step();
    check("t36_first_gnt", 32'(gnt), 'b0010);
    repeat (4) step();
    check("t36_first_end", 32'(gnt), 0);
    step();
    check("t36_second_gnt", 32'(gnt), 'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester channel and of the output.
REQ-002 Parameter MAX_BURST, default 4, maximum beats per grant (legal range 1..16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  4  per-requester beat-valid; bit i belongs to requester i.
REQ-006 in_data  input  4*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-007 in_ready  output  4  per-requester beat-accept, combinational.
REQ-008 out_valid  output  1  registered output beat valid.
REQ-009 out_data  output  WIDTH  registered output beat data.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 sel  output  2  registered 4:1 mux select of the current or most recent grant.
REQ-012 gnt  output  4  registered one-hot grant, all-zero when no grant.
REQ-013 busy  output  1  high while in GRANT state.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 In IDLE, gnt SHALL be 0 and in_ready SHALL be 0.
REQ-016 In IDLE with any in_valid bit high, the block SHALL select the first valid requester searching ptr, ptr+1, ... (mod 4), load sel/gnt, clear beat_cnt and enter GRANT on the next edge (one-cycle arbitration latency).
REQ-017 In GRANT, in_ready[sel] SHALL equal (!out_valid || out_ready); other in_ready bits SHALL be 0.
REQ-018 A beat transfers when in_valid[sel] && in_ready[sel]; on that edge out_data <= in_data[sel], out_valid <= 1, beat_cnt increments.
REQ-019 out_valid SHALL clear when out_ready is high and no beat transfers that cycle; out_data SHALL hold when no beat transfers.
REQ-020 GRANT SHALL exit to IDLE on the edge where the transferring beat makes beat_cnt reach MAX_BURST.
REQ-021 GRANT SHALL exit to IDLE on the edge where in_ready[sel] is 1 and in_valid[sel] is 0 (requester idle); a stalled output (in_ready 0) SHALL NOT end the grant.
REQ-022 On every GRANT exit, ptr SHALL become sel+1 mod 4, gnt SHALL clear, sel SHALL hold its value.
REQ-023 A requester that keeps in_valid high SHALL be served again no earlier than after every other simultaneously valid requester has had one grant (round-robin fairness).
REQ-024 The output register SHALL drain in IDLE per REQ-019; a pending out_valid SHALL not block re-arbitration.
REQ-025 Changes on in_valid of non-granted requesters during GRANT SHALL have no effect until the next IDLE.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, out_valid 0, out_data 0, sel 0, gnt 0, ptr 0, beat_cnt 0, busy 0, in_ready 0.
REQ-027 Reset asserted mid-burst SHALL discard the burst with no further output beat; after release, arbitration starts from requester 0.

Structure
REQ-028 A shared package mux_arb_pkg SHALL hold the FSM state enum, NUM_REQ = 4 and SEL_W = 2.
REQ-029 The rotating priority search SHALL be a combinational sub-module rr_pick4 (inputs: request vector, ptr; outputs: found, index).
REQ-030 The datapath select SHALL be a plain 4:1 select indexed by sel; no other sub-modules.

Verification
REQ-031 Reset then in_valid=0001, data0=0x11, out_ready=1: gnt=0001 one cycle after valid, out_data=0x11 one cycle later, busy high.
REQ-032 All four valid continuously, MAX_BURST=4, out_ready=1: grants in order 0,1,2,3,0 with exactly 4 beats each and a one-cycle IDLE gap between grants.
REQ-033 Requester 2 alone sends 2 beats then drops valid: grant ends after 2 beats, ptr=3, next valid from requester 1 with requester 3 also valid selects 3.
REQ-034 Burst from requester 1 with out_ready held low for 5 cycles after first beat: in_ready[1]=0 during stall, out_data holds, grant persists, burst completes 4 beats after release.
REQ-035 rst_n pulsed low during beat 2 of a requester-3 burst: outputs zero immediately, no remaining beats emitted, next grant with all valid goes to requester 0.
REQ-036 Simultaneous in_valid=1010 from IDLE with ptr=0: requester 1 granted first, then requester 3.
